// File: rtl/prog_loader_if.sv
// prog_loader_if -- byte-stream input and imem write port of the program loader.
//
// Signals:
//   in_valid / in_data / in_ready : byte stream from the host (valid/ready handshake)
//   imem_we / imem_addr / imem_wdata : word write port towards instruction memory
//
// Modports:
//   master : host / bench side (drives the byte stream, observes the imem port)
//   slave  : the loader itself
interface prog_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader -- receives a program as a byte stream and writes it word by word
// into instruction memory, holding the core in reset until the load completes.
//
// Stream: count[7:0], count[15:8], then count little-endian 32-bit words.
// Optional build macro LOADER_CKSUM_EN adds a trailing checksum byte that must
// equal the XOR of every preceding byte of the stream.
//
// Ports:
//   clk          : system clock
//   reset        : asynchronous, active-low reset
//   bus          : prog_loader_if.slave (byte stream in, imem write port out)
//   core_reset   : active-high reset to the processor, released after the load
//   busy         : load in progress (header, data and checksum phases)
//   done         : load complete and core released (sticky until reset)
//   error        : load aborted (sticky until reset)
//   words_loaded : number of words written so far
module prog_loader #(
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 1024,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    prog_loader_if.slave      bus,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int             HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [16:0]    DEPTH_L   = 17'(DEPTH);

    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DATA,
`ifdef LOADER_CKSUM_EN
        S_CKSUM,
`endif
        S_RELEASE,
        S_RUN,
        S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         count_q, count_d;
    logic [1:0]          idx_q, idx_d;
    logic [23:0]         buf_q, buf_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
`ifdef LOADER_CKSUM_EN
    logic [7:0]          xor_q, xor_d;
`endif

    logic                ready_st;
    logic                busy_st;
    logic                take;
    logic [15:0]         hdr;
    logic                last_word;

    // Full 16-bit count as it stands once the high header byte is taken.
    assign hdr       = {bus.in_data, count_q[7:0]};
    assign last_word = (17'(words_q) + 17'd1) == {1'b0, count_q};
    assign take      = bus.in_valid & ready_st;

    // ---- next-state / datapath ----
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        idx_d    = idx_q;
        buf_d    = buf_q;
        words_d  = words_q;
        hold_d   = hold_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
`ifdef LOADER_CKSUM_EN
        xor_d    = xor_q;
`endif
        ready_st = 1'b0;
        busy_st  = 1'b0;

        case (state_q)
            S_HDR0: begin
                ready_st = 1'b1;
                busy_st  = 1'b1;
                if (take) begin
                    count_d[7:0] = bus.in_data;
`ifdef LOADER_CKSUM_EN
                    xor_d        = bus.in_data;
`endif
                    state_d      = S_HDR1;
                end
            end

            S_HDR1: begin
                ready_st = 1'b1;
                busy_st  = 1'b1;
                if (take) begin
                    count_d = hdr;
                    idx_d   = 2'd0;
                    hold_d  = '0;
`ifdef LOADER_CKSUM_EN
                    xor_d   = xor_q ^ bus.in_data;
`endif
                    if (hdr == 16'd0) begin
`ifdef LOADER_CKSUM_EN
                        state_d = S_CKSUM;
`else
                        state_d = S_RELEASE;
`endif
                    end else if ({1'b0, hdr} > DEPTH_L) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                ready_st = 1'b1;
                busy_st  = 1'b1;
                if (take) begin
`ifdef LOADER_CKSUM_EN
                    xor_d = xor_q ^ bus.in_data;
`endif
                    idx_d = idx_q + 2'd1;
                    case (idx_q)
                        2'd0: buf_d[7:0]   = bus.in_data;
                        2'd1: buf_d[15:8]  = bus.in_data;
                        2'd2: buf_d[23:16] = bus.in_data;
                        default: begin
                            // Word address equals the number of words already written.
                            we_d    = 1'b1;
                            addr_d  = words_q[ADDR_W-1:0];
                            wdata_d = {bus.in_data, buf_q};
                            words_d = words_q + (ADDR_W+1)'(1);
                            if (last_word) begin
                                hold_d = '0;
`ifdef LOADER_CKSUM_EN
                                state_d = S_CKSUM;
`else
                                state_d = S_RELEASE;
`endif
                            end
                        end
                    endcase
                end
            end

`ifdef LOADER_CKSUM_EN
            S_CKSUM: begin
                ready_st = 1'b1;
                busy_st  = 1'b1;
                if (take) begin
                    hold_d  = '0;
                    state_d = (bus.in_data == xor_q) ? S_RELEASE : S_ERROR;
                end
            end
`endif

            S_RELEASE: begin
                // Last edge of the hold window moves to RUN, dropping core_reset.
                if (hold_q == HOLD_LAST) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            S_RUN:   ;
            S_ERROR: ;

            default: state_d = S_ERROR;
        endcase
    end

    // ---- state registers ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_HDR0;
            count_q <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            words_q <= '0;
            hold_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef LOADER_CKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            words_q <= words_d;
            hold_q  <= hold_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef LOADER_CKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    // The FSM rests in HDR0 while reset is low, so handshake and busy are
    // gated by reset to keep them low during reset.
    assign bus.in_ready   = reset & ready_st;
    assign busy           = reset & busy_st;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign core_reset     = (state_q != S_RUN);
    assign done           = (state_q == S_RUN);
    assign error          = (state_q == S_ERROR);
    assign words_loaded   = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader -- scoreboard bench for prog_loader. Stimulus pushes the
// expected imem writes into a queue; a monitor pops and compares on every
// imem_we. Load outcome (done/error, latency, counters) is checked per load.
module tb_prog_loader;

    localparam int ADDR_W      = 10;
    localparam int DEPTH       = 1024;
    localparam int HOLD_CYCLES = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            core_reset;
    logic            busy;
    logic            done;
    logic            error;
    logic [ADDR_W:0] words_loaded;

    prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    prog_loader #(
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .core_reset   (core_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] stim[$];
    int         vectors = 0;
    int         miscompares = 0;
    bit         ok;
    int         rcnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every write strobe must match the next expected write.
    always @(negedge clk) begin
        wr_t e;
        if (bus.imem_we === 1'b1) begin
            check("write_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.imem_addr), 32'(e.addr));
                check("wr_data", bus.imem_wdata, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input int cycles);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        reset        = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            check("rst_core_reset", core_reset, 1);
            check("rst_in_ready", bus.in_ready, 0);
            check("rst_imem_we", bus.imem_we, 0);
            check("rst_flags", {busy, done, error}, 0);
            check("rst_words", words_loaded, 0);
            check("rst_addr_wdata", bus.imem_wdata | 32'(bus.imem_addr), 0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);
        check("post_rst_busy", busy, 1);
    endtask

    // Offer one byte; returns once it has been accepted (or the bound expires).
    task automatic send_byte(input logic [7:0] b, input int mode, output bit acc);
        int guard;
        guard = 0;
        acc   = 1'b1;
        if (mode == 1) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end else if (mode == 2) begin
            repeat ($urandom_range(0, 2)) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1) begin
            guard++;
            if (guard > 50) begin
                check("in_ready_timeout", bus.in_ready, 1);
                acc = 1'b0;
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic stim_header(input int cnt);
        stim.delete();
        stim.push_back(cnt[7:0]);
        stim.push_back(cnt[15:8]);
    endtask

    task automatic stim_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) stim.push_back(w[8*k +: 8]);
    endtask

    task automatic stim_close();
`ifdef LOADER_CKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        foreach (stim[i]) x ^= stim[i];
        stim.push_back(x);
`endif
    endtask

    // Reference model: parse the stream, queue the expected writes, predict outcome.
    task automatic run_load(input int mode, input string tag);
        int  cnt;
        int  nsend;
        int  n;
        bit  exp_err;
        bit  acc;
        wr_t w;
`ifdef LOADER_CKSUM_EN
        logic [7:0] x;
`endif
        cnt     = int'({stim[1], stim[0]});
        exp_err = 1'b0;
        if (cnt > DEPTH) begin
            exp_err = 1'b1;
            nsend   = 2;
        end else begin
            for (int i = 0; i < cnt; i++) begin
                w.addr = ADDR_W'(i);
                w.data = {stim[2+4*i+3], stim[2+4*i+2], stim[2+4*i+1], stim[2+4*i]};
                exp_q.push_back(w);
            end
            nsend = 2 + 4 * cnt;
`ifdef LOADER_CKSUM_EN
            x = 8'h00;
            for (int j = 0; j < nsend; j++) x ^= stim[j];
            exp_err = (stim[nsend] != x);
            nsend++;
`endif
        end

        check({tag, "_busy_idle"}, busy, 1);
        for (int j = 0; j < nsend; j++) begin
            send_byte(stim[j], mode, acc);
            if (!acc) break;
        end

        n = 0;
        while (done !== 1'b1 && error !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_err) begin
            check({tag, "_error"}, error, 1);
            check({tag, "_done"}, done, 0);
            check({tag, "_core_reset"}, core_reset, 1);
        end else begin
            check({tag, "_done"}, done, 1);
            check({tag, "_release_latency"}, n, HOLD_CYCLES);
            check({tag, "_core_reset"}, core_reset, 0);
            check({tag, "_error"}, error, 0);
            check({tag, "_words_loaded"}, words_loaded, cnt);
        end
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_writes_drained"}, exp_q.size(), 0);

        // Terminal states ignore further input.
        repeat (4) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check({tag, "_sticky"}, {done, error, core_reset}, exp_err ? 3'b011 : 3'b100);
        exp_q.delete();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        do_reset(5);

        stim = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        stim_close();
        run_load(0, "two_word");

        do_reset(1);
        run_load(1, "toggle");

        do_reset(1);
        stim = '{8'h00, 8'h00};
        stim_close();
        run_load(0, "empty");

        do_reset(1);
        stim = '{8'h01, 8'h04};
        run_load(0, "oversize");

        do_reset(1);
        stim = '{8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC};
        for (int j = 0; j < 5; j++) send_byte(stim[j], 0, ok);
        check("partial_words", words_loaded, 0);
        check("partial_core_reset", core_reset, 1);
        do_reset(2);
        stim = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        stim_close();
        run_load(0, "restart");

`ifdef LOADER_CKSUM_EN
        do_reset(1);
        stim = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        run_load(0, "ck_good");

        do_reset(1);
        stim = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
        run_load(0, "ck_bad");
`endif

        for (int r = 0; r < 10; r++) begin
            do_reset(1);
            if (r == 9) begin
                rcnt = $urandom_range(DEPTH + 1, 65535);
                stim_header(rcnt);
            end else begin
                rcnt = $urandom_range(0, 6);
                stim_header(rcnt);
                repeat (rcnt) stim_word($urandom);
                stim_close();
`ifdef LOADER_CKSUM_EN
                if ($urandom_range(0, 3) == 0)
                    stim[stim.size()-1] ^= 8'(1 << $urandom_range(0, 7));
`endif
            end
            run_load($urandom_range(0, 2), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer-side counterpart to the processor's instruction memory: receives a program as a byte stream and writes it word-by-word into imem.
- Holds the pipelined core in reset until the load completes, then releases it.
- Sits between the bench/host byte source and the top-level imem write port and core reset input.

Parameters:
- ADDR_W, 10, imem word-address width.
- DEPTH, 1024, maximum number of words accepted (must be <= 2^ADDR_W).
- HOLD_CYCLES, 4, cycles core_reset stays high after entering RELEASE (must be >= 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  loader can accept a byte.
- imem_we  out  1  imem write strobe, one cycle per word.
- imem_addr  out  ADDR_W  imem word address.
- imem_wdata  out  32  imem write data.
- core_reset  out  1  active-high reset to the processor top.
- busy  out  1  load in progress (HDR0..CKSUM).
- done  out  1  load complete, core released (sticky).
- error  out  1  load aborted (sticky).
- words_loaded  out  ADDR_W+1  count of words written so far.

Behaviour:
- Design has one clock; reset is asynchronous and active-low.
- While reset is low, outputs are: in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, core_reset 1, busy 0, done 0, error 0, words_loaded 0.
- After reset is released, the FSM is in HDR0.
- Stream format:
  - Byte 0 is count[7:0]; byte 1 is count[15:8].
  - Then count words, 4 bytes each, little-endian; byte k lands in wdata[8k+7:8k].
- A byte is accepted on a rising edge with in_valid && in_ready.
- in_ready = 1 in HDR0, HDR1, DATA and CKSUM; it is 0 in all other states.
- States:
  - HDR0: on accept, store count low byte, then go to HDR1.
  - HDR1: on accept, store count high byte, then:
    - count == 0: go to RELEASE (CKSUM first if the optional feature is enabled).
    - count > DEPTH: go to ERROR.
    - otherwise: go to DATA.
  - DATA: a 2-bit byte index selects the lane. On the 4th byte:
    - The assembled word and the current word address are registered.
    - imem_we is high for exactly the following cycle.
    - Word address increments and words_loaded increments.
    - Byte index wraps to 0.
    - When this is the last word, go to RELEASE (or CKSUM).
  - RELEASE: the hold counter counts from 0.
    - On the HOLD_CYCLES-th rising edge after entry, core_reset goes 0 and done goes 1, then the FSM enters RUN.
    - HOLD_CYCLES >= 1 guarantees the final imem_we completes while the core is held in reset.
  - RUN: terminal. in_ready 0, core_reset 0, done 1; input is ignored until reset.
  - ERROR: terminal. error 1, core_reset 1, in_ready 0; imem is never written after entry.
- in_valid low stalls in any state, with no timeout.
- Word accept is back-to-back capable: a new byte may be accepted in the same cycle that imem_we is high for the previous word.
- imem_addr and imem_wdata hold their last value when imem_we is 0.
- Reset asserted mid-load returns all state to reset values immediately (asynchronous). Partially written imem contents are left as-is, and the next load restarts from HDR0.

Optional Feature:
- Macro: LOADER_CKSUM_EN.
- Enabled:
  - A running XOR is kept over every accepted byte, headers included.
  - After the last data word (or after HDR1 when count == 0), the FSM enters CKSUM and accepts one byte.
  - Byte equals the running XOR: go to RELEASE. Otherwise: go to ERROR.
- Disabled: no CKSUM state, no XOR register; transitions go directly to RELEASE.

Test Plan:
- Reset held low for 5 cycles -> core_reset=1, in_ready=0, imem_we=0 throughout; after reset release, in_ready=1 next cycle.
- Stream 02 00 78 56 34 12 EF BE AD DE, in_valid always 1 -> two imem_we pulses: addr 0 / 0x12345678, then addr 1 / 0xDEADBEEF. words_loaded=2. core_reset falls HOLD_CYCLES (4) edges after RELEASE entry; done=1.
- Same stream with in_valid toggling 1/0 every cycle -> identical writes and values; only the timing stretches.
- Header 00 00 -> no imem_we; done=1 four cycles after the HDR1 accept. Header 01 04 (count 1025 > DEPTH) -> error=1, core_reset stays 1, in_ready=0.
- Reset pulsed low after 3 data bytes, then a full 1-word stream 01 00 AA BB CC DD -> single write addr 0 / 0xDDCCBBAA; done=1.
- With LOADER_CKSUM_EN: stream 01 00 11 22 33 44 plus trailer 45 -> done=1. Trailer 00 -> error=1 and core_reset stays 1.
